// File: rtl/pu_riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pu_riscv_pkg
// Description : Shared decode constants, state encoding and the M-extension
//               multiply decoder used by the execute-stage units.
// Revision    : 1.0 - initial release
// ============================================================================
package pu_riscv_pkg;

    localparam logic [4:0]  OPC_OP   = 5'b01100;
    localparam logic [4:0]  OPC_OP32 = 5'b01110;

    localparam logic [1:0]  RV32I    = 2'b01;

    // Key layout: {func7, func3, opcode[6:2]}
    localparam logic [14:0] MUL      = {7'b0000001, 3'b000, OPC_OP};
    localparam logic [14:0] MULH     = {7'b0000001, 3'b001, OPC_OP};
    localparam logic [14:0] MULHSU   = {7'b0000001, 3'b010, OPC_OP};
    localparam logic [14:0] MULHU    = {7'b0000001, 3'b011, OPC_OP};
    localparam logic [14:0] MULW     = {7'b0000001, 3'b000, OPC_OP32};

    typedef logic [1:0] state_t;
    localparam state_t ST_CHK = 2'b00;
    localparam state_t ST_MUL = 2'b01;
    localparam state_t ST_RES = 2'b10;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_MUL    = 3'd1,
        OP_MULH   = 3'd2,
        OP_MULHSU = 3'd3,
        OP_MULHU  = 3'd4,
        OP_MULW   = 3'd5
    } mul_op_t;

    // MULW does not exist in 32-bit mode, so it decodes to nothing there
    function automatic mul_op_t mul_decode(input logic xlen32, input logic [31:0] instr);
        logic [14:0] key;
        key = {instr[31:25], instr[14:12], instr[6:2]};
        case (key)
            MUL:     return OP_MUL;
            MULH:    return OP_MULH;
            MULHSU:  return OP_MULHSU;
            MULHU:   return OP_MULHU;
            MULW:    return xlen32 ? OP_NONE : OP_MULW;
            default: return OP_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pu_riscv_mul.sv
`default_nettype none
// ============================================================================
// Module      : pu_riscv_mul
// Description : Bit-serial RV64M/RV32M multiplier (MUL/MULH/MULHSU/MULHU/MULW)
//               with a zero-operand shortcut and pipeline stall output.
// Revision    : 1.0 - initial release
// ============================================================================
module pu_riscv_mul
    import pu_riscv_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 64
)(
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_stall,
    output logic            mul_stall,
    input  logic            id_bubble,
    input  logic [ILEN-1:0] id_instr,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [1:0]      st_xlen,
    output logic            mul_bubble,
    output logic [XLEN-1:0] mul_r
);

    localparam int                  c_cnt_bits = $clog2(XLEN);
    localparam logic [c_cnt_bits-1:0] c_cnt_full = c_cnt_bits'(XLEN - 1);
    localparam logic [c_cnt_bits-1:0] c_cnt_word = c_cnt_bits'(31);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

    function automatic logic [2*XLEN-1:0] twos(input logic [2*XLEN-1:0] x);
        return ~x + (2*XLEN)'(1);
    endfunction

    function automatic logic [XLEN-1:0] abs(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? (~x + XLEN'(1)) : x;
    endfunction

    state_t                r_state;
    logic [c_cnt_bits-1:0] r_cnt;
    logic [XLEN-1:0]       r_acc;
    logic [XLEN-1:0]       r_mpl;
    logic [XLEN-1:0]       r_mcd;
    logic                  r_neg;
    logic [31:0]           r_mul_instr;

    logic                  w_xlen32;
    mul_op_t               w_op;
    mul_op_t               w_res_op;
    logic                  w_zero;
    logic [XLEN-1:0]       w_mcd;
    logic [XLEN-1:0]       w_mpl;
    logic                  w_neg;
    logic [XLEN:0]         w_sum;
    logic [2*XLEN-1:0]     w_prod;
    logic [2*XLEN-1:0]     w_q;
    logic [31:0]           w_word_lo;
    logic [XLEN-1:0]       w_result;
    logic                  w_unused_instr;

    assign w_xlen32       = (st_xlen == RV32I);
    assign w_op           = mul_decode(w_xlen32, id_instr[31:0]);
    assign w_res_op       = mul_decode(w_xlen32, r_mul_instr);
    assign w_unused_instr = ^id_instr;

    assign w_zero = (w_op == OP_MULW) ? ((opA[31:0] == 32'd0) || (opB[31:0] == 32'd0))
                                      : ((opA == '0) || (opB == '0));

    always_comb begin
        w_mcd = opA;
        w_mpl = opB;
        w_neg = 1'b0;
        case (w_op)
            OP_MUL, OP_MULH: begin
                w_mcd = abs(opA);
                w_mpl = abs(opB);
                w_neg = opA[XLEN-1] ^ opB[XLEN-1];
            end
            OP_MULHSU: begin
                w_mcd = abs(opA);
                w_neg = opA[XLEN-1];
            end
            OP_MULW: begin
                w_mcd = {{(XLEN-32){1'b0}}, opA[31:0]};
                w_mpl = {{(XLEN-32){1'b0}}, opB[31:0]};
            end
            default: ;
        endcase
    end

    assign w_sum  = {1'b0, r_acc} + {1'b0, (r_mpl[0] ? r_mcd : {XLEN{1'b0}})};
    assign w_prod = {r_acc, r_mpl};
    assign w_q    = r_neg ? twos(w_prod) : w_prod;

    // After only 32 shifts the word product still sits XLEN-32 bits up
    assign w_word_lo = w_prod[(XLEN-32) +: 32];

    always_comb begin
        w_result = '0;
        case (w_res_op)
            OP_MUL:                        w_result = w_q[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_result = w_q[2*XLEN-1:XLEN];
            OP_MULW:                       w_result = sext32(w_word_lo);
            default:                       w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!ex_stall) r_mul_instr <= id_instr[31:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_CHK;
            mul_bubble <= 1'b1;
            mul_stall  <= 1'b0;
            mul_r      <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mpl      <= '0;
            r_mcd      <= '0;
            r_neg      <= 1'b0;
        end else begin
            mul_bubble <= 1'b1;
            case (r_state)
                ST_CHK: begin
                    if (!ex_stall && !id_bubble && (w_op != OP_NONE)) begin
                        if (w_zero) begin
                            mul_r      <= '0;
                            mul_bubble <= 1'b0;
                        end else begin
                            r_state   <= ST_MUL;
                            mul_stall <= 1'b1;
                            r_acc     <= '0;
                            r_mcd     <= w_mcd;
                            r_mpl     <= w_mpl;
                            r_neg     <= w_neg;
                            r_cnt     <= (w_op == OP_MULW) ? c_cnt_word : c_cnt_full;
                        end
                    end
                end
                ST_MUL: begin
                    {r_acc, r_mpl} <= {w_sum, r_mpl[XLEN-1:1]};
                    r_cnt          <= r_cnt - c_cnt_bits'(1);
                    if (r_cnt == '0) r_state <= ST_RES;
                end
                ST_RES: begin
                    r_state    <= ST_CHK;
                    mul_stall  <= 1'b0;
                    mul_bubble <= 1'b0;
                    mul_r      <= w_result;
                end
                default: r_state <= ST_CHK;
            endcase
        end
    end

endmodule
`default_nettype wire
